// File: rtl/csr_system_sequencer.sv
// csr_system_sequencer
//   Multi-cycle sequencer for SYSTEM / MISC-MEM instructions (CSRRW/S/C,
//   CSRRWI/SI/CI, ECALL, EBREAK, FENCE, FENCE.I). Accepts one instruction at
//   a time, drives the register-file read/write ports and the CSR-file bus,
//   and reports retirement, traps and fetch-flush requests to the core.
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   instr_valid/instr/instr_ready  instruction handshake (ready only when idle)
//   done, trap, trap_cause     retirement pulse, trap pulse + mcause code
//   rs1_sel/rs1_data           register-file read port
//   rd_sel/rd_data/rd_we       register-file write port (old CSR value)
//   csr_addr/csr_re/csr_we/csr_wdata/csr_rdata/csr_ack/csr_err  CSR bus
//   mem_idle, flush_i          FENCE drain input, FENCE.I fetch flush pulse
module csr_system_sequencer #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned CSR_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic            done,
    output logic [4:0]      rs1_sel,
    input  logic [XLEN-1:0] rs1_data,
    output logic [4:0]      rd_sel,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_we,
    output logic [11:0]     csr_addr,
    output logic            csr_re,
    output logic            csr_we,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            csr_ack,
    input  logic            csr_err,
    input  logic            mem_idle,
    output logic            flush_i,
    output logic            trap,
    output logic [3:0]      trap_cause
);

    typedef enum logic [2:0] {
        IDLE, RS1, CSR_RD, CSR_WR, WB, FENCE, DONE, TRAP
    } state_t;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_BREAK   = 4'd3;
    localparam logic [3:0] CAUSE_ECALL   = 4'd11;

    state_t          state_q, state_d;
    logic [11:0]     csr_q, csr_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] src_q, src_d;
    logic [XLEN-1:0] old_q, old_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      cause_q, cause_d;

    logic is_w, do_read, do_write, timeout;

    assign is_w     = (f3_q[1:0] == 2'b01);
    assign do_read  = !(is_w && (rd_q == 5'd0));
    assign do_write = is_w || (rs1_q != 5'd0);
    assign timeout  = (cnt_q == 4'(CSR_TIMEOUT - 1));

    assign rs1_sel  = rs1_q;
    assign rd_sel   = rd_q;
    assign csr_addr = csr_q;
    assign rd_data  = old_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            csr_q   <= '0;
            rs1_q   <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
            src_q   <= '0;
            old_q   <= '0;
            cnt_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            csr_q   <= csr_d;
            rs1_q   <= rs1_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            src_q   <= src_d;
            old_q   <= old_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // The wait counter defaults to zero, so any state change clears it and it
    // only advances while a CSR access is stalled.
    always_comb begin
        state_d     = state_q;
        csr_d       = csr_q;
        rs1_d       = rs1_q;
        rd_d        = rd_q;
        f3_d        = f3_q;
        src_d       = src_q;
        old_d       = old_q;
        cnt_d       = '0;
        cause_d     = cause_q;
        instr_ready = 1'b0;
        done        = 1'b0;
        trap        = 1'b0;
        trap_cause  = '0;
        rd_we       = 1'b0;
        csr_re      = 1'b0;
        csr_we      = 1'b0;
        csr_wdata   = '0;
        flush_i     = 1'b0;

        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    csr_d   = instr[31:20];
                    rs1_d   = instr[19:15];
                    f3_d    = instr[14:12];
                    rd_d    = instr[11:7];
                    src_d   = XLEN'(instr[19:15]);
                    old_d   = '0;
                    cause_d = CAUSE_ILLEGAL;
                    state_d = TRAP;
                    if (instr[6:0] == 7'h73) begin
                        if (instr[14:12] == 3'b000) begin
                            if (instr[31:7] == 25'd0)
                                cause_d = CAUSE_ECALL;
                            else if (instr[31:7] == {12'h001, 13'd0})
                                cause_d = CAUSE_BREAK;
                        end else if (instr[14:12] != 3'b100) begin
                            state_d = instr[14] ? CSR_RD : RS1;
                        end
                    end else if (instr[6:0] == 7'h0F && instr[14:13] == 2'b00) begin
                        state_d = FENCE;
                    end
                end
            end
            RS1: begin
                src_d   = rs1_data;
                state_d = CSR_RD;
            end
            // Skipped accesses still occupy their state for one idle cycle,
            // which keeps latency independent of rd/rs1 being x0.
            CSR_RD: begin
                if (!do_read) begin
                    state_d = CSR_WR;
                end else begin
                    csr_re = 1'b1;
                    if (csr_err) begin
                        cause_d = CAUSE_ILLEGAL;
                        state_d = TRAP;
                    end else if (csr_ack) begin
                        old_d   = csr_rdata;
                        state_d = CSR_WR;
                    end else if (timeout) begin
                        cause_d = CAUSE_ILLEGAL;
                        state_d = TRAP;
                    end else begin
                        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 4'd1;
                    end
                end
            end
            CSR_WR: begin
                if (!do_write) begin
                    state_d = WB;
                end else begin
                    csr_we = 1'b1;
                    case (f3_q[1:0])
                        2'b01:   csr_wdata = src_q;
                        2'b10:   csr_wdata = old_q | src_q;
                        default: csr_wdata = old_q & ~src_q;
                    endcase
                    if (csr_err) begin
                        cause_d = CAUSE_ILLEGAL;
                        state_d = TRAP;
                    end else if (csr_ack) begin
                        state_d = WB;
                    end else if (timeout) begin
                        cause_d = CAUSE_ILLEGAL;
                        state_d = TRAP;
                    end else begin
                        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 4'd1;
                    end
                end
            end
            WB: begin
                rd_we   = (rd_q != 5'd0);
                state_d = DONE;
            end
            FENCE: begin
                if (mem_idle) begin
                    flush_i = f3_q[0];
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            TRAP: begin
                done       = 1'b1;
                trap       = 1'b1;
                trap_cause = cause_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
